// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: show-ahead byte stream from the receive FIFO to its consumer
// data  : head byte (0 while valid is low)
// valid : a byte is available
// ready : consumer takes the byte at this posedge
interface uart_rx_fifo_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    modport master (output data, valid, input ready);
    modport slave  (input data, valid, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead byte FIFO, with RTS flow control and sticky line-error flags
// clk       : system clock
// clr       : synchronous active-low reset
// rx        : asynchronous serial input, idle high
// bus       : data/valid/ready byte stream (master side)
// rts_n     : 0 = host may send; 1 once free entries <= RTS_MARGIN
// overrun   : sticky, a byte was dropped on a full FIFO
// frame_err : sticky, a stop bit was sampled low
// err_clr   : clears both sticky flags (a same-cycle set wins)
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 2500,
    parameter int DEPTH_LOG2   = 4,
    parameter int RTS_MARGIN   = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  rx,
    uart_rx_fifo_if.master        bus,
    output logic                  rts_n,
    output logic                  overrun,
    output logic                  frame_err,
    input  logic                  err_clr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = DEPTH_LOG2;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH   = (AW + 1)'(2 ** AW);
    localparam logic [AW:0]   MARGIN  = (AW + 1)'(RTS_MARGIN);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    sh, sh_n;
    logic          rx_m, rx_s;
    logic          push, ferr, pop, accept;
    logic [7:0]    mem [2 ** AW];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_n;
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        bit_n   = bit_cnt;
        sh_n    = sh;
        push    = 1'b0;
        ferr    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (!rx_s) state_n = START;
            end
            START: if (cnt == HALF_M1) begin
                cnt_n   = '0;
                state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt == BIT_M1) begin
                cnt_n = '0;
                sh_n  = {rx_s, sh[7:1]};
                bit_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_n = STOP;
            end
            STOP: if (cnt == BIT_M1) begin
                cnt_n   = '0;
                push    = rx_s;
                ferr    = !rx_s;
                state_n = rx_s ? IDLE : BREAK;
            end
            BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // a full FIFO still takes a byte when the consumer frees a slot on the same edge
    assign pop       = bus.valid && bus.ready;
    assign accept    = push && (count < DEPTH || pop);
    assign count_n   = count + (AW + 1)'(accept) - (AW + 1)'(pop);
    assign bus.valid = count != '0;
    assign bus.data  = bus.valid ? mem[rd_ptr] : 8'h00;
    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rts_n     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_n;
            sh        <= sh_n;
            rx_m      <= rx;
            rx_s      <= rx_m;
            wr_ptr    <= wr_ptr + AW'(accept);
            rd_ptr    <= rd_ptr + AW'(pop);
            count     <= count_n;
            rts_n     <= (DEPTH - count_n) <= MARGIN;
            overrun   <= (push && !accept) || (overrun && !err_clr);
            frame_err <= ferr || (frame_err && !err_clr);
        end
    end
    always_ff @(posedge clk) begin
        if (clr && accept) mem[wr_ptr] <= sh;
    end
endmodule
